// File: rtl/exc_pkg.sv
// Shared cause codes and FSM state encoding for the exception sequencer.
package exc_pkg;

  localparam logic [3:0] CAUSE_IRQ    = 4'd0;
  localparam logic [3:0] CAUSE_ADDR   = 4'd4;
  localparam logic [3:0] CAUSE_DIV0   = 4'd9;
  localparam logic [3:0] CAUSE_OVF    = 4'd12;
  localparam logic [3:0] CAUSE_DOUBLE = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_VECTOR  = 3'd2,
    S_HANDLER = 3'd3,
    S_RETURN  = 3'd4,
    S_HALT    = 3'd5
  } exc_state_t;

endpackage

// File: rtl/exc_priority_enc.sv
// Fixed-priority cause encoder: req = {addr, div0, ovf, irq}, addr highest.
module exc_priority_enc
  import exc_pkg::*;
(
  input  logic [3:0] req,
  output logic       valid,
  output logic [3:0] cause
);

  always_comb begin
    valid = |req;
    cause = CAUSE_IRQ;
    if (req[3])      cause = CAUSE_ADDR;
    else if (req[2]) cause = CAUSE_DIV0;
    else if (req[1]) cause = CAUSE_OVF;
  end

endmodule

// File: rtl/exception_sequencer.sv
// Exception entry/return sequencer: captures EPC/cause, flushes, vectors to the
// handler, returns on ERET, and halts on a fault taken inside the handler.
module exception_sequencer
  import exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_VEC  = 32'h0000_0080,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_addr,
  input  logic        exc_div0,
  input  logic        exc_ovf,
  input  logic        irq,
  input  logic        eret,
  input  logic [31:0] pc_cur,
  input  logic [31:0] alu_addr,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic [31:0] epc,
  output logic [3:0]  cause,
  output logic [31:0] bad_vaddr,
  output logic        in_handler,
  output logic        halted
);

  localparam int CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  exc_state_t    state, state_n;
  logic [CW-1:0] cnt;
  logic          req_valid;
  logic [3:0]    req_cause;
  logic          fault;
  logic [31:0]   ret_target;

  exc_priority_enc u_prio (
    .req   ({exc_addr, exc_div0, exc_ovf, irq}),
    .valid (req_valid),
    .cause (req_cause)
  );

  // irq is deliberately excluded: it is masked while in the handler
  assign fault = exc_addr | exc_div0 | exc_ovf;

  // An interrupted instruction never executed, so it is re-run on return
  assign ret_target = (cause == CAUSE_IRQ) ? epc : epc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      epc       <= '0;
      cause     <= CAUSE_IRQ;
      bad_vaddr <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (req_valid) begin
          epc   <= pc_cur;
          cause <= req_cause;
          cnt   <= CW'(FLUSH_CYCLES);
          if (req_cause == CAUSE_ADDR) bad_vaddr <= alu_addr;
        end
        S_FLUSH:   cnt <= cnt - CW'(1);
        S_HANDLER: if (fault) cause <= CAUSE_DOUBLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (req_valid) state_n = S_FLUSH;
      S_FLUSH:   if (cnt == CW'(1)) state_n = S_VECTOR;
      S_VECTOR:  state_n = S_HANDLER;
      S_HANDLER: begin
        if (fault)     state_n = S_HALT;
        else if (eret) state_n = S_RETURN;
      end
      S_RETURN:  state_n = S_IDLE;
      S_HALT:    state_n = S_HALT;
      default:   state_n = S_IDLE;
    endcase
  end

  always_comb begin
    flush       = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = HANDLER_VEC;
    in_handler  = 1'b0;
    halted      = 1'b0;
    case (state)
      S_FLUSH:   flush = 1'b1;
      S_VECTOR:  pc_redirect = 1'b1;
      S_HANDLER: in_handler = 1'b1;
      S_RETURN: begin
        flush       = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = ret_target;
      end
      S_HALT: begin
        flush  = 1'b1;
        halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
